// File: rtl/apb2_bldc_master_pkg.sv
// ---------------------------------------------------------------------------
// apb2_bldc_master_pkg
// Shared types and constants for the bldc APB2 bus. The master uses the
// state enum. The register map lives here so the master, the bldc slave and
// any software-facing bench all agree on the byte addresses.
// ---------------------------------------------------------------------------
package apb2_bldc_master_pkg;

    // APB2 initiator phases: idle, one-cycle SETUP, ACCESS until pready.
    typedef enum logic [1:0] {
        APBM_IDLE   = 2'd0,
        APBM_SETUP  = 2'd1,
        APBM_ACCESS = 2'd2
    } apb_master_state_t;

    // bldc register byte addresses. All are 4-byte aligned.
    localparam logic [7:0] BLDC_REG_STATUS  = 8'h00;
    localparam logic [7:0] BLDC_REG_CTRL    = 8'h04;
    localparam logic [7:0] BLDC_REG_DUTY    = 8'h08;
    localparam logic [7:0] BLDC_REG_PERIOD  = 8'h0c;
    localparam logic [7:0] BLDC_REG_SPEED   = 8'h10;
    localparam logic [7:0] BLDC_REG_POS     = 8'h14;
    localparam logic [7:0] BLDC_REG_FAULT   = 8'h18;
    localparam logic [7:0] BLDC_REG_TGT_POS = 8'h1c;

endpackage

// File: rtl/apb2_bldc_master.sv
// ---------------------------------------------------------------------------
// apb2_bldc_master
// APB2 initiator for the bldc peripheral bus. It takes one command at a time
// on a valid/ready handshake, runs the APB2 SETUP and ACCESS phases, and
// reports completion on a one-cycle response strobe.
//
// Ports
//   pclk, preset                 clock (posedge) and async active-high reset
//   cmd_valid/cmd_ready          command handshake (single outstanding)
//   cmd_write/cmd_addr/cmd_wdata command contents
//   rsp_valid                    one-cycle completion strobe
//   rsp_rdata/rsp_err            read data (0 for writes) and slave error
//   rsp_timeout                  completion was forced by the wait timeout
//   psel/penable/pwrite/paddr/pwdata/pstrb/pprot   APB2 request outputs
//   prdata/pready/pslverr        APB2 slave response inputs
//
// Configuration
//   APB2_BLDC_MASTER_TIMEOUT_EN  when defined, an ACCESS phase that sees
//   pready low for timeout_cycles cycles is aborted with rsp_err and
//   rsp_timeout set. When undefined, ACCESS waits forever and rsp_timeout
//   is tied low.
// ---------------------------------------------------------------------------
module apb2_bldc_master
    import apb2_bldc_master_pkg::*;
#(
    parameter int data_width     = 32,
    parameter int addr_width     = 8,
    parameter int timeout_cycles = 256
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [addr_width-1:0]     cmd_addr,
    input  logic [data_width-1:0]     cmd_wdata,
    output logic                      rsp_valid,
    output logic [data_width-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      rsp_timeout,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [addr_width-1:0]     paddr,
    output logic [data_width-1:0]     pwdata,
    output logic [data_width/8-1:0]   pstrb,
    output logic [2:0]                pprot,
    input  logic [data_width-1:0]     prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    localparam int StrbW = data_width / 8;

    // Clears the two low address bits so every access is word aligned.
    localparam logic [addr_width-1:0] AlignMask = ~{{(addr_width-2){1'b0}}, 2'b11};

    apb_master_state_t           state_q, state_d;
    logic                        psel_q, psel_d;
    logic                        penable_q, penable_d;
    logic                        pwrite_q, pwrite_d;
    logic [addr_width-1:0]       paddr_q, paddr_d;
    logic [data_width-1:0]       pwdata_q, pwdata_d;
    logic [StrbW-1:0]            pstrb_q, pstrb_d;
    logic                        rspValid_q, rspValid_d;
    logic [data_width-1:0]       rspRdata_q, rspRdata_d;
    logic                        rspErr_q, rspErr_d;

`ifdef APB2_BLDC_MASTER_TIMEOUT_EN
    localparam int CntW = $clog2(timeout_cycles) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(timeout_cycles - 1);

    logic [CntW-1:0]             waitCnt_q, waitCnt_d;
    logic                        rspTimeout_q, rspTimeout_d;
`endif

    // State and registered bus outputs. Reset drops psel/penable at once,
    // so a transfer cut by reset never produces a response.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q      <= APBM_IDLE;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            pstrb_q      <= '0;
            rspValid_q   <= 1'b0;
            rspRdata_q   <= '0;
            rspErr_q     <= 1'b0;
`ifdef APB2_BLDC_MASTER_TIMEOUT_EN
            waitCnt_q    <= '0;
            rspTimeout_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            psel_q       <= psel_d;
            penable_q    <= penable_d;
            pwrite_q     <= pwrite_d;
            paddr_q      <= paddr_d;
            pwdata_q     <= pwdata_d;
            pstrb_q      <= pstrb_d;
            rspValid_q   <= rspValid_d;
            rspRdata_q   <= rspRdata_d;
            rspErr_q     <= rspErr_d;
`ifdef APB2_BLDC_MASTER_TIMEOUT_EN
            waitCnt_q    <= waitCnt_d;
            rspTimeout_q <= rspTimeout_d;
`endif
        end
    end

    // Next-state logic. Bus outputs hold by default, so address and data
    // stay stable through ACCESS and keep their last value afterwards. The
    // response flags default low, which makes rsp_valid a single-cycle pulse.
    always_comb begin
        state_d      = state_q;
        psel_d       = psel_q;
        penable_d    = penable_q;
        pwrite_d     = pwrite_q;
        paddr_d      = paddr_q;
        pwdata_d     = pwdata_q;
        pstrb_d      = pstrb_q;
        rspValid_d   = 1'b0;
        rspRdata_d   = rspRdata_q;
        rspErr_d     = 1'b0;
`ifdef APB2_BLDC_MASTER_TIMEOUT_EN
        waitCnt_d    = waitCnt_q;
        rspTimeout_d = 1'b0;
`endif

        case (state_q)
            APBM_IDLE: begin
                if (cmd_valid) begin
                    paddr_d   = cmd_addr & AlignMask;
                    pwdata_d  = cmd_wdata;
                    pwrite_d  = cmd_write;
                    pstrb_d   = cmd_write ? {StrbW{1'b1}} : {StrbW{1'b0}};
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    state_d   = APBM_SETUP;
                end
            end

            APBM_SETUP: begin
                penable_d = 1'b1;
                state_d   = APBM_ACCESS;
`ifdef APB2_BLDC_MASTER_TIMEOUT_EN
                waitCnt_d = '0;
`endif
            end

            APBM_ACCESS: begin
                if (pready) begin
                    psel_d     = 1'b0;
                    penable_d  = 1'b0;
                    pstrb_d    = '0;
                    rspValid_d = 1'b1;
                    rspRdata_d = pwrite_q ? '0 : prdata;
                    rspErr_d   = pslverr;
                    state_d    = APBM_IDLE;
                end
`ifdef APB2_BLDC_MASTER_TIMEOUT_EN
                // The final allowed wait cycle has passed without pready.
                else if (waitCnt_q == CntLast) begin
                    psel_d       = 1'b0;
                    penable_d    = 1'b0;
                    pstrb_d      = '0;
                    rspValid_d   = 1'b1;
                    rspRdata_d   = '0;
                    rspErr_d     = 1'b1;
                    rspTimeout_d = 1'b1;
                    state_d      = APBM_IDLE;
                end else begin
                    waitCnt_d = waitCnt_q + 1'b1;
                end
`endif
            end

            default: begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                state_d   = APBM_IDLE;
            end
        endcase
    end

    // Ready is decoded from state, so it rises in the same cycle as rsp_valid
    // and a back-to-back command can be taken then.
    assign cmd_ready = (state_q == APBM_IDLE);
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;
    assign pprot     = 3'b000;
    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rspRdata_q;
    assign rsp_err   = rspErr_q;
`ifdef APB2_BLDC_MASTER_TIMEOUT_EN
    assign rsp_timeout = rspTimeout_q;
`else
    assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_apb2_bldc_master.sv
// ---------------------------------------------------------------------------
// tb_apb2_bldc_master
// Directed bench for the APB2 bldc master. Inputs change one time unit after
// a rising edge or on a falling edge; outputs are observed on falling edges.
// The APB2 slave is played directly by each test through pready/prdata/pslverr.
// ---------------------------------------------------------------------------
module tb_apb2_bldc_master;
    import apb2_bldc_master_pkg::*;

    logic        pclk;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int total = 0;
    int bad   = 0;

    apb2_bldc_master #(
        .data_width     (32),
        .addr_width     (8),
        .timeout_cycles (8)
    ) dut (
        .pclk        (pclk),
        .preset      (preset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_write   (cmd_write),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .psel        (psel),
        .penable     (penable),
        .pwrite      (pwrite),
        .paddr       (paddr),
        .pwdata      (pwdata),
        .pstrb       (pstrb),
        .pprot       (pprot),
        .prdata      (prdata),
        .pready      (pready),
        .pslverr     (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Presents a command right after a rising edge, lets the next edge accept
    // it, then withdraws it. On return the DUT is in SETUP.
    task automatic issue_cmd(input logic wr, input logic [7:0] addr, input logic [31:0] wdata);
        @(posedge pclk); #1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        prdata = '0; pready = 1'b1; pslverr = 1'b0;
        repeat (2) @(negedge pclk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
        total++; if ({psel, penable, pwrite} !== 3'b000) begin bad++; $display("[TB] FAIL reset_ctrl got=%b exp=000", {psel, penable, pwrite}); end
        total++; if ({paddr, pwdata, pstrb} !== 44'h0) begin bad++; $display("[TB] FAIL reset_bus got=%h exp=0", {paddr, pwdata, pstrb}); end
        total++; if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== 35'h0) begin bad++; $display("[TB] FAIL reset_rsp got=%h exp=0", {rsp_valid, rsp_err, rsp_timeout, rsp_rdata}); end
        total++; if (pprot !== 3'b000) begin bad++; $display("[TB] FAIL reset_pprot got=%b exp=000", pprot); end
        preset = 1'b0;
    endtask

    // Write with an always-ready slave: psel two cycles, penable one,
    // response in the third cycle after the accept cycle.
    task automatic test_write_fast();
        int nSel = 0, nEn = 0, nRsp = 0, rspAt = -1;
        logic [3:0] strbSetup = 'x;
        logic errAtRsp = 'x;
        pready = 1'b1; pslverr = 1'b0;
        issue_cmd(1'b1, BLDC_REG_SPEED, 32'h0000_0005);
        for (int i = 1; i <= 6; i++) begin
            @(negedge pclk);
            if (i == 1) begin
                strbSetup = pstrb;
                total++; if ({psel, penable, pwrite, paddr, pwdata} !== {3'b101, 8'h10, 32'h5}) begin bad++; $display("[TB] FAIL wr_setup got=%h exp=%h", {psel, penable, pwrite, paddr, pwdata}, {3'b101, 8'h10, 32'h5}); end
                total++; if (cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL wr_setup_ready got=%b exp=0", cmd_ready); end
            end
            nSel += int'(psel);
            nEn  += int'(penable);
            if (rsp_valid) begin
                nRsp++;
                if (rspAt < 0) begin rspAt = i; errAtRsp = rsp_err; end
            end
        end
        total++; if (strbSetup !== 4'hf) begin bad++; $display("[TB] FAIL wr_pstrb got=%h exp=f", strbSetup); end
        total++; if (nSel !== 2) begin bad++; $display("[TB] FAIL wr_psel_cycles got=%0d exp=2", nSel); end
        total++; if (nEn !== 1) begin bad++; $display("[TB] FAIL wr_penable_cycles got=%0d exp=1", nEn); end
        total++; if (nRsp !== 1 || rspAt !== 3) begin bad++; $display("[TB] FAIL wr_rsp_timing got count=%0d at=%0d exp count=1 at=3", nRsp, rspAt); end
        total++; if (errAtRsp !== 1'b0) begin bad++; $display("[TB] FAIL wr_rsp_err got=%b exp=0", errAtRsp); end
        total++; if ({pstrb, paddr, pwdata} !== {4'h0, 8'h10, 32'h5}) begin bad++; $display("[TB] FAIL wr_after got=%h exp=%h", {pstrb, paddr, pwdata}, {4'h0, 8'h10, 32'h5}); end
    endtask

    // Read with four wait cycles; controls must not move while waiting.
    task automatic test_read_wait();
        int rspAt = -1, unstable = 0;
        logic [31:0] rdAtRsp = 'x;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'h0;
        issue_cmd(1'b0, BLDC_REG_CTRL, 32'hFFFF_FFFF);
        for (int i = 1; i <= 10; i++) begin
            @(negedge pclk);
            if (i >= 2 && i <= 6 && {psel, penable, pwrite, paddr, pstrb} !== {3'b110, 8'h04, 4'h0}) unstable++;
            if (rsp_valid && rspAt < 0) begin rspAt = i; rdAtRsp = rsp_rdata; end
            if (i == 6) begin pready = 1'b1; prdata = 32'h1234_5678; end
            if (i == 7) prdata = 32'h0;
        end
        total++; if (unstable !== 0) begin bad++; $display("[TB] FAIL rd_stable got=%0d unstable cycles exp=0", unstable); end
        total++; if (rspAt !== 7) begin bad++; $display("[TB] FAIL rd_rsp_at got=%0d exp=7", rspAt); end
        total++; if (rdAtRsp !== 32'h1234_5678) begin bad++; $display("[TB] FAIL rd_rdata got=%h exp=12345678", rdAtRsp); end
    endtask

    // Slave error on a read, then a write issued during the response cycle.
    task automatic test_back_to_back();
        int rspAt = -1;
        pready = 1'b1; pslverr = 1'b1; prdata = 32'hCAFE_0001;
        issue_cmd(1'b0, BLDC_REG_TGT_POS, 32'h0);
        repeat (2) @(negedge pclk);
        @(negedge pclk);
        total++; if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110) begin bad++; $display("[TB] FAIL err_rsp got=%b exp=110", {rsp_valid, rsp_err, rsp_timeout}); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready got=%b exp=1", cmd_ready); end
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = BLDC_REG_DUTY; cmd_wdata = 32'hAABB_CCDD;
        @(negedge pclk);
        cmd_valid = 1'b0; pslverr = 1'b0;
        total++; if ({psel, penable, pwrite, paddr, pwdata} !== {3'b101, 8'h08, 32'hAABB_CCDD}) begin bad++; $display("[TB] FAIL b2b_setup got=%h exp=%h", {psel, penable, pwrite, paddr, pwdata}, {3'b101, 8'h08, 32'hAABB_CCDD}); end
        for (int i = 1; i <= 4; i++) begin
            @(negedge pclk);
            if (rsp_valid && rspAt < 0) begin
                rspAt = i;
                total++; if ({rsp_err, rsp_rdata} !== 33'h0) begin bad++; $display("[TB] FAIL b2b_rsp got=%h exp=0", {rsp_err, rsp_rdata}); end
            end
        end
        total++; if (rspAt !== 2) begin bad++; $display("[TB] FAIL b2b_rsp_at got=%0d exp=2", rspAt); end
    endtask

    // pready high in IDLE and SETUP must not complete; also an unaligned address.
    task automatic test_no_premature();
        int rspAt = -1, early = 0;
        pready = 1'b1; pslverr = 1'b0; prdata = 32'h0000_00A5;
        issue_cmd(1'b0, 8'h17, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            @(negedge pclk);
            if (i == 1) begin
                total++; if (paddr !== 8'h14) begin bad++; $display("[TB] FAIL align_paddr got=%h exp=14", paddr); end
            end
            if (i == 2) pready = 1'b0;
            if (i >= 2 && i <= 4 && (rsp_valid || !penable)) early++;
            if (rsp_valid && rspAt < 0) rspAt = i;
            if (i == 4) pready = 1'b1;
        end
        total++; if (early !== 0) begin bad++; $display("[TB] FAIL premature got=%0d bad cycles exp=0", early); end
        total++; if (rspAt !== 5) begin bad++; $display("[TB] FAIL premature_rsp_at got=%0d exp=5", rspAt); end
    endtask

    // Slave never ready: aborts after 8 ACCESS cycles when the timeout is
    // built in, otherwise the transfer just keeps waiting.
    task automatic test_timeout();
        int rspAt = -1, held = 0;
        logic [33:0] rspBits = 'x;
        pready = 1'b0; pslverr = 1'b0; prdata = 32'hDEAD_BEEF;
`ifdef APB2_BLDC_MASTER_TIMEOUT_EN
        issue_cmd(1'b0, BLDC_REG_FAULT, 32'h0);
        for (int i = 1; i <= 14; i++) begin
            @(negedge pclk);
            if (rsp_valid && rspAt < 0) begin rspAt = i; rspBits = {rsp_err, rsp_timeout, rsp_rdata}; end
        end
        total++; if (rspAt !== 10) begin bad++; $display("[TB] FAIL timeout_rsp_at got=%0d exp=10", rspAt); end
        total++; if (rspBits !== {2'b11, 32'h0}) begin bad++; $display("[TB] FAIL timeout_rsp got=%h exp=%h", rspBits, {2'b11, 32'h0}); end
        total++; if ({psel, penable, cmd_ready} !== 3'b001) begin bad++; $display("[TB] FAIL timeout_idle got=%b exp=001", {psel, penable, cmd_ready}); end
        pready = 1'b1;
`else
        issue_cmd(1'b0, BLDC_REG_FAULT, 32'h0);
        for (int i = 1; i <= 40; i++) begin
            @(negedge pclk);
            if (rsp_valid && rspAt < 0) rspAt = i;
            if (psel && penable) held++;
        end
        total++; if (rspAt !== -1) begin bad++; $display("[TB] FAIL no_timeout_rsp got=%0d exp=-1", rspAt); end
        total++; if (held !== 39) begin bad++; $display("[TB] FAIL no_timeout_hold got=%0d exp=39", held); end
        pready = 1'b1;
        rspAt = -1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge pclk);
            if (rsp_valid && rspAt < 0) begin rspAt = i; rspBits = {rsp_err, rsp_timeout, rsp_rdata}; end
        end
        total++; if (rspAt !== 1 || rspBits !== {2'b00, 32'hDEAD_BEEF}) begin bad++; $display("[TB] FAIL late_rsp got at=%0d bits=%h exp at=1 bits=%h", rspAt, rspBits, {2'b00, 32'hDEAD_BEEF}); end
`endif
    endtask

    // Reset during ACCESS: bus drops at once and no response ever appears.
    task automatic test_reset_mid();
        int pulses = 0, notReady = 0;
        pready = 1'b0; pslverr = 1'b0;
        issue_cmd(1'b1, BLDC_REG_PERIOD, 32'h0000_0100);
        repeat (2) @(negedge pclk);
        total++; if ({psel, penable} !== 2'b11) begin bad++; $display("[TB] FAIL rst_mid_pre got=%b exp=11", {psel, penable}); end
        preset = 1'b1;
        #1;
        total++; if ({psel, penable, cmd_ready} !== 3'b001) begin bad++; $display("[TB] FAIL rst_mid_async got=%b exp=001", {psel, penable, cmd_ready}); end
        pready = 1'b1;
        @(negedge pclk);
        preset = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge pclk);
            if (rsp_valid) pulses++;
            if (!cmd_ready || psel) notReady++;
        end
        total++; if (pulses !== 0) begin bad++; $display("[TB] FAIL rst_mid_rsp got=%0d pulses exp=0", pulses); end
        total++; if (notReady !== 0) begin bad++; $display("[TB] FAIL rst_mid_idle got=%0d cycles exp=0", notReady); end
    endtask

    initial begin
        test_reset();
        test_write_fast();
        test_read_wait();
        test_back_to_back();
        test_no_premature();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
